// File: rtl/clock_crossing_arb_pkg.sv
// ---------------------------------------------------------------------------
// clock_crossing_arb_pkg
//   Shared constants and helpers for the slave-side arbiter of the io
//   clock-crossing bridge.
//   MAX_REQ : largest number of requesters the arbiter supports
//   ID_W    : width of a requester index. It is sized for MAX_REQ so that one
//             index type serves every legal NUM_REQ.
//   rrPick  : round-robin pick of the first active request at or after a
//             pointer, wrapping at numReq.
// ---------------------------------------------------------------------------
package clock_crossing_arb_pkg;

    localparam int MAX_REQ = 8;
    localparam int ID_W    = $clog2(MAX_REQ);

    // Walks the requesters in order, starting at ptr and wrapping at numReq.
    // It returns the first one that is asserting a request. When nothing is
    // requesting, it returns ptr; the caller qualifies the result with the
    // request bit of the chosen requester.
    function automatic logic [ID_W-1:0] rrPick(input logic [MAX_REQ-1:0] request,
                                               input logic [ID_W-1:0]    ptr,
                                               input int                 numReq);
        logic [ID_W-1:0] pick;
        logic            found;
        int              idx;
        pick  = ptr;
        found = 1'b0;
        for (int i = 0; i < MAX_REQ; i++) begin
            if (i < numReq) begin
                idx = int'(ptr) + i;
                if (idx >= numReq) begin
                    idx = idx - numReq;
                end
                if (!found && request[idx]) begin
                    pick  = ID_W'(idx);
                    found = 1'b1;
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/clock_crossing_arb_id_fifo.sv
// ---------------------------------------------------------------------------
// clock_crossing_arb_id_fifo
//   Synchronous in-order FIFO holding the requester index of every read that
//   is still outstanding at the bridge. The head entry names the requester
//   that owns the next bridge read response.
// Ports
//   slave_clk, slave_reset_n : bridge slave clock, async active-low reset
//   push_i, pushId_i         : enqueue the index of an accepted read
//   pop_i                    : dequeue the head (response delivered)
//   headId_o                 : oldest outstanding requester index
//   count_o                  : number of entries held (0..DEPTH)
//   empty_o                  : no entries held
// The caller must not push while full or pop while empty.
// ---------------------------------------------------------------------------
module clock_crossing_arb_id_fifo
    import clock_crossing_arb_pkg::*;
#(
    parameter int WIDTH = ID_W,
    parameter int DEPTH = 64
) (
    input  logic             slave_clk,
    input  logic             slave_reset_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] pushId_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] headId_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wrPtr_q, wrPtr_d;
    logic [AW-1:0]    rdPtr_q, rdPtr_d;
    logic [AW:0]      count_q, count_d;

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    // When a push and a pop happen in the same cycle, the count does not change.
    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (push_i) begin
            wrPtr_d = wrPtr_q + 1'b1;
        end
        if (pop_i) begin
            rdPtr_d = rdPtr_q + 1'b1;
        end
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge slave_clk or negedge slave_reset_n) begin
        if (!slave_reset_n) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
        end
    end

    // The storage has no reset. An entry is read only after it has been written.
    always_ff @(posedge slave_clk) begin
        if (push_i) begin
            mem[wrPtr_q] <= pushId_i;
        end
    end

    assign headId_o = mem[rdPtr_q];
    assign count_o  = count_q;
    assign empty_o  = (count_q == '0);

endmodule

// File: rtl/clock_crossing_slave_arbiter.sv
// ---------------------------------------------------------------------------
// clock_crossing_slave_arbiter
//   Shares the slave port (s1) of the io clock-crossing bridge between
//   NUM_REQ pipelined Avalon-MM requesters in the slave_clk domain.
//   - Round-robin grant per transfer. A grant that the bridge stalls is
//     locked until the bridge accepts it.
//   - Reads are issued only while fewer than MAX_PENDING are outstanding.
//   - An in-order ID FIFO steers each bridge read response to the requester
//     that issued the read, one cycle after the bridge delivers it.
// Ports
//   req_*     : packed per-requester Avalon-MM master side (requester i at
//               slice i). waitrequest is per requester. readdata and
//               endofpacket are broadcast, and readdatavalid is one-hot.
//   bridge_*  : Avalon-MM master toward bridge s1
//   pending_count : reads issued to the bridge and not yet answered
//   rsp_underflow : sticky; a response arrived with nothing outstanding
// ---------------------------------------------------------------------------
module clock_crossing_slave_arbiter
    import clock_crossing_arb_pkg::*;
#(
    parameter int NUM_REQ     = 2,
    parameter int ADDR_W      = 5,
    parameter int DATA_W      = 32,
    parameter int BE_W        = 4,
    parameter int MAX_PENDING = 64
) (
    input  logic                      slave_clk,
    input  logic                      slave_reset_n,
    input  logic [NUM_REQ*ADDR_W-1:0] req_address,
    input  logic [NUM_REQ*ADDR_W-1:0] req_nativeaddress,
    input  logic [NUM_REQ*BE_W-1:0]   req_byteenable,
    input  logic [NUM_REQ*DATA_W-1:0] req_writedata,
    input  logic [NUM_REQ-1:0]        req_read,
    input  logic [NUM_REQ-1:0]        req_write,
    output logic [NUM_REQ-1:0]        req_waitrequest,
    output logic [DATA_W-1:0]         req_readdata,
    output logic [NUM_REQ-1:0]        req_readdatavalid,
    output logic                      req_endofpacket,
    output logic [ADDR_W-1:0]         bridge_address,
    output logic [ADDR_W-1:0]         bridge_nativeaddress,
    output logic [BE_W-1:0]           bridge_byteenable,
    output logic [DATA_W-1:0]         bridge_writedata,
    output logic                      bridge_read,
    output logic                      bridge_write,
    input  logic                      bridge_waitrequest,
    input  logic [DATA_W-1:0]         bridge_readdata,
    input  logic                      bridge_readdatavalid,
    input  logic                      bridge_endofpacket,
    output logic [$clog2(MAX_PENDING):0] pending_count,
    output logic                      rsp_underflow
);

    localparam int CNT_W = $clog2(MAX_PENDING) + 1;

    logic [MAX_REQ-1:0] readVec, writeVec, requestVec;
    logic [ID_W-1:0]    rrPtr_q, rrPtr_d;
    logic [ID_W-1:0]    lockId_q, lockId_d;
    logic               locked_q, locked_d;
    logic [ID_W-1:0]    grant;
    logic               grantRead, grantWrite;
    logic               readBlocked, issue, accept;

    logic [ID_W-1:0]    headId;
    logic [CNT_W-1:0]   fifoCount;
    logic               fifoEmpty, fifoPush, fifoPop;

    logic [NUM_REQ-1:0] rspValid_q, rspValid_d;
    logic [DATA_W-1:0]  rspData_q, rspData_d;
    logic               rspEop_q, rspEop_d;
    logic               underflow_q, underflow_d;

    // The strobes are widened to MAX_REQ bits. An ID_W-wide grant can then
    // index them without range problems for any NUM_REQ.
    always_comb begin
        readVec  = '0;
        writeVec = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            readVec[i]  = req_read[i];
            writeVec[i] = req_write[i];
        end
        requestVec = readVec | writeVec;
    end

    // Grant selection and issue. A locked grant ignores other requesters
    // until the bridge takes it. When both strobes are set, the write is issued.
    // A read is held back while the ID FIFO is full. A response popping in
    // the same cycle does not free a slot until the next cycle.
    always_comb begin
        grant       = locked_q ? lockId_q : rrPick(requestVec, rrPtr_q, NUM_REQ);
        grantWrite  = writeVec[grant];
        grantRead   = readVec[grant] & ~writeVec[grant];
        readBlocked = (fifoCount == CNT_W'(MAX_PENDING));
        issue       = grantWrite | (grantRead & ~readBlocked);
        accept      = issue & ~bridge_waitrequest;
    end

    // Combinational mux of the granted requester onto bridge s1.
    always_comb begin
        bridge_address       = req_address[0 +: ADDR_W];
        bridge_nativeaddress = req_nativeaddress[0 +: ADDR_W];
        bridge_byteenable    = req_byteenable[0 +: BE_W];
        bridge_writedata     = req_writedata[0 +: DATA_W];
        req_waitrequest      = '1;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant == ID_W'(i)) begin
                bridge_address       = req_address[i*ADDR_W +: ADDR_W];
                bridge_nativeaddress = req_nativeaddress[i*ADDR_W +: ADDR_W];
                bridge_byteenable    = req_byteenable[i*BE_W +: BE_W];
                bridge_writedata     = req_writedata[i*DATA_W +: DATA_W];
                req_waitrequest[i]   = ~accept;
            end
        end
        bridge_write = grantWrite;
        bridge_read  = grantRead & ~readBlocked;
    end

    // Round-robin pointer and lock update. An accepted transfer moves
    // priority past the winner. A stalled transfer pins the grant.
    always_comb begin
        rrPtr_d  = rrPtr_q;
        locked_d = locked_q;
        lockId_d = lockId_q;
        if (accept) begin
            rrPtr_d  = (grant == ID_W'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
            locked_d = 1'b0;
        end else if (issue) begin
            locked_d = 1'b1;
            lockId_d = grant;
        end
    end

    always_ff @(posedge slave_clk or negedge slave_reset_n) begin
        if (!slave_reset_n) begin
            rrPtr_q  <= '0;
            locked_q <= 1'b0;
            lockId_q <= '0;
        end else begin
            rrPtr_q  <= rrPtr_d;
            locked_q <= locked_d;
            lockId_q <= lockId_d;
        end
    end

    assign fifoPush = accept & grantRead;
    assign fifoPop  = bridge_readdatavalid & ~fifoEmpty;

    clock_crossing_arb_id_fifo #(
        .WIDTH (ID_W),
        .DEPTH (MAX_PENDING)
    ) idFifo (
        .slave_clk     (slave_clk),
        .slave_reset_n (slave_reset_n),
        .push_i        (fifoPush),
        .pushId_i      (grant),
        .pop_i         (fifoPop),
        .headId_o      (headId),
        .count_o       (fifoCount),
        .empty_o       (fifoEmpty)
    );

    // Response steering. A response with no outstanding read produces no
    // strobe and does not pop the FIFO. It does set the sticky underflow flag.
    always_comb begin
        rspValid_d  = '0;
        rspData_d   = rspData_q;
        rspEop_d    = rspEop_q;
        underflow_d = underflow_q | (bridge_readdatavalid & fifoEmpty);
        if (bridge_readdatavalid) begin
            rspData_d = bridge_readdata;
            rspEop_d  = bridge_endofpacket;
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (fifoPop && headId == ID_W'(i)) begin
                rspValid_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge slave_clk or negedge slave_reset_n) begin
        if (!slave_reset_n) begin
            rspValid_q  <= '0;
            rspData_q   <= '0;
            rspEop_q    <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            rspValid_q  <= rspValid_d;
            rspData_q   <= rspData_d;
            rspEop_q    <= rspEop_d;
            underflow_q <= underflow_d;
        end
    end

    assign req_readdatavalid = rspValid_q;
    assign req_readdata      = rspData_q;
    assign req_endofpacket   = rspEop_q;
    assign pending_count     = fifoCount;
    assign rsp_underflow     = underflow_q;

endmodule
